virtio_available_ring_scheduler: RTL and testbench
==================================================

// Module: virtio_available_ring_scheduler
// PURPOSE
//  Shares one memory-read request channel between NUM_QUEUES available ring handlers.
//  Round-robin arbitrates handler requests, tags each with its queue index and forwards it.
//  Limits outstanding reads per queue and routes read responses back by queue index.
//  Sits between the per-virtqueue available ring handlers and the shared memory read engine.
// PARAMETERS
//  NUM_QUEUES       4   number of handler request/response ports, >= 2
//  MAX_OUTSTANDING  4   max in-flight requests per queue, >= 1
//  QUEUE_W          $clog2(NUM_QUEUES)  queue index width (derived, localparam)
// PORTS
//  aclk          in   1              clock
//  areset_n      in   1              asynchronous active-low reset
//  req_tvalid    in   NUM_QUEUES     per-handler request valid
//  req_tready    out  NUM_QUEUES     per-handler request ready
//  req_tid       in   NUM_QUEUES*2   per-handler request type (request_type_t)
//  req_tdata     in   NUM_QUEUES*32  per-handler request {length[15:0], offset[15:0]}
//  mem_tvalid    out  1              request to memory engine valid
//  mem_tready    in   1              memory engine ready
//  mem_tid       out  2+QUEUE_W      {queue index, request type}
//  mem_tdata     out  32             forwarded request payload
//  cpl_tvalid    in   1              response from memory engine valid
//  cpl_tready    out  1              response ready
//  cpl_tdest     in   QUEUE_W        response queue index
//  cpl_tlast     in   1              last beat of one request's response
//  cpl_tdata     in   32             response payload
//  rsp_tvalid    out  NUM_QUEUES     per-handler response valid (one-hot)
//  rsp_tready    in   NUM_QUEUES     per-handler response ready
//  rsp_tlast     out  1              broadcast tlast
//  rsp_tdata     out  32             broadcast response payload
//  error         out  1              sticky: response to nonexistent queue index
// BEHAVIOUR
//  Reset: mem_tvalid=0, req_tready=0, cpl_tready=0, rsp_tvalid=0, error=0; grant pointer=0;
//   all outstanding counters=0; mem_tid/mem_tdata undefined (not reset).
//  Eligible queue q: req_tvalid[q] && outstanding[q] < MAX_OUTSTANDING.
//  Output register: loaded when (!mem_tvalid || mem_tready) and any queue eligible.
//   Winner = first eligible queue at or after grant pointer (wrapping); req_tready[winner]=1
//   same cycle (combinational), others 0. Grant pointer <= winner+1 mod NUM_QUEUES.
//  Latency: req accept -> mem_tvalid next cycle; back-to-back 1 req/cycle while mem_tready=1.
//  mem_tvalid held with stable mem_tid/mem_tdata until mem_tready (AXI4-Stream rules).
//  Outstanding[q] +1 on accept from q; -1 on cpl_tvalid&&cpl_tready&&cpl_tlast with tdest=q;
//   both same cycle on same q -> unchanged. Counter width $clog2(MAX_OUTSTANDING+1).
//  Counter at MAX_OUTSTANDING: q skipped, pointer does not stall on it.
//  Response path: pass-through, combinational. rsp_tvalid[cpl_tdest]=cpl_tvalid;
//   cpl_tready=rsp_tready[cpl_tdest]. cpl_tdest >= NUM_QUEUES: beat consumed
//   (cpl_tready=1), no rsp_tvalid, error<=1, no counter change.
//  Counter underflow (completion with counter 0): saturate at 0, error<=1.
//  No queue eligible: output register keeps draining, nothing new loaded.
//  Reset mid-operation: in-flight state discarded; memory engine reset in same domain.
// STRUCTURE
//  virtio_available_ring_pkg: add scheduler_tid_t {queue, request_type_t}; reuse
//   request_t, response_t, request_type_t.
//  Sub-module virtio_available_ring_scheduler_arbiter: round-robin grant
//   (eligible vector + pointer -> one-hot grant + next pointer), purely combinational + ptr reg.
//  Top: output register, outstanding counters (generate per queue), response demux, error.
// TESTING
//  Q0..Q3 all valid, mem_tready=1 -> mem_tid queue order 0,1,2,3,0,... one per cycle.
//  Only Q2 valid, offsets 0x10,0x20 -> two beats queue=2, payload unchanged, 1-cycle latency.
//  Q1 issues 4 with no completions (MAX_OUTSTANDING=4) -> req_tready[1]=0; Q3 still served;
//   one tlast completion tdest=1 -> Q1 accepted again next arbitration.
//  mem_tready=0 for 5 cycles with mem_tvalid=1 -> mem_tid/mem_tdata stable, no req_tready.
//  Completion tdest=1 tlast same cycle as Q1 accept -> outstanding[1] unchanged.
//  NUM_QUEUES=3, cpl_tdest=3 -> cpl_tready=1, rsp_tvalid=0, error=1 until reset;
//   assert areset_n low mid-burst -> all outputs/counters at reset values.

Source files
------------

// File: rtl/virtio_available_ring_pkg.sv
// Shared types for the virtio available ring handlers and the request scheduler.
package virtio_available_ring_pkg;

  typedef enum logic [1:0] {
    RT_AVAIL_IDX  = 2'd0,
    RT_AVAIL_RING = 2'd1,
    RT_DESC       = 2'd2,
    RT_INDIRECT   = 2'd3
  } request_type_t;

  typedef struct packed {
    logic [15:0] length;
    logic [15:0] offset;
  } request_t;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } response_t;

  localparam int SCHED_MAX_QUEUE_W = 8;

  // Wide enough for any realistic queue count; the top packs only QUEUE_W bits onto mem_tid.
  typedef struct packed {
    logic [SCHED_MAX_QUEUE_W-1:0] queue;
    request_type_t                rtype;
  } scheduler_tid_t;

endpackage

// File: rtl/virtio_available_ring_scheduler_arbiter.sv
// Round-robin grant: first eligible queue at or after the pointer, pointer moves past the winner.
module virtio_available_ring_scheduler_arbiter #(
  parameter  int NUM_QUEUES = 4,
  localparam int QUEUE_W    = $clog2(NUM_QUEUES)
) (
  input  logic                  aclk,
  input  logic                  areset_n,
  input  logic [NUM_QUEUES-1:0] eligible_i,
  input  logic                  advance_i,
  output logic [NUM_QUEUES-1:0] grant_o,
  output logic [QUEUE_W-1:0]    winner_o,
  output logic                  any_o
);

  localparam int W1 = QUEUE_W + 1;

  logic [QUEUE_W-1:0] ptr_q, ptr_d;
  logic [W1-1:0]      idx;
  logic [W1-1:0]      nxt;

  // Scan from the farthest offset back to the pointer so the nearest eligible queue wins.
  always_comb begin
    idx      = '0;
    winner_o = '0;
    for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
      idx = W1'(ptr_q) + W1'(i);
      if (idx >= W1'(NUM_QUEUES)) idx = idx - W1'(NUM_QUEUES);
      if (eligible_i[idx[QUEUE_W-1:0]]) winner_o = idx[QUEUE_W-1:0];
    end
  end

  assign any_o = |eligible_i;

  always_comb begin
    grant_o = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      grant_o[q] = any_o && (winner_o == QUEUE_W'(q));
    end
  end

  assign nxt   = W1'(winner_o) + W1'(1);
  assign ptr_d = (nxt == W1'(NUM_QUEUES)) ? '0 : nxt[QUEUE_W-1:0];

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n)      ptr_q <= '0;
    else if (advance_i) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/virtio_available_ring_scheduler.sv
// Shares one memory read request channel between NUM_QUEUES available ring handlers and
// routes completions back by queue index, bounding in-flight reads per queue.
module virtio_available_ring_scheduler
  import virtio_available_ring_pkg::*;
#(
  parameter  int NUM_QUEUES      = 4,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int QUEUE_W         = $clog2(NUM_QUEUES)
) (
  input  logic                     aclk,
  input  logic                     areset_n,
  input  logic [NUM_QUEUES-1:0]    req_tvalid,
  output logic [NUM_QUEUES-1:0]    req_tready,
  input  logic [NUM_QUEUES*2-1:0]  req_tid,
  input  logic [NUM_QUEUES*32-1:0] req_tdata,
  output logic                     mem_tvalid,
  input  logic                     mem_tready,
  output logic [2+QUEUE_W-1:0]     mem_tid,
  output logic [31:0]              mem_tdata,
  input  logic                     cpl_tvalid,
  output logic                     cpl_tready,
  input  logic [QUEUE_W-1:0]       cpl_tdest,
  input  logic                     cpl_tlast,
  input  logic [31:0]              cpl_tdata,
  output logic [NUM_QUEUES-1:0]    rsp_tvalid,
  input  logic [NUM_QUEUES-1:0]    rsp_tready,
  output logic                     rsp_tlast,
  output logic [31:0]              rsp_tdata,
  output logic                     error
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_QUEUES-1:0] elig, grant, hit, uflow;
  logic [QUEUE_W-1:0]    winner;
  logic                  any_elig, load, dest_valid, cpl_fire;

  logic                  mem_tvalid_q;
  logic [QUEUE_W-1:0]    mem_queue_q;
  request_type_t         mem_type_q;
  request_t              mem_req_q;
  logic                  error_q;

  virtio_available_ring_scheduler_arbiter #(.NUM_QUEUES(NUM_QUEUES)) u_arbiter (
    .aclk       (aclk),
    .areset_n   (areset_n),
    .eligible_i (elig),
    .advance_i  (load),
    .grant_o    (grant),
    .winner_o   (winner),
    .any_o      (any_elig)
  );

  assign load       = areset_n && any_elig && (!mem_tvalid_q || mem_tready);
  assign req_tready = load ? grant : '0;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n)       mem_tvalid_q <= 1'b0;
    else if (load)       mem_tvalid_q <= 1'b1;
    else if (mem_tready) mem_tvalid_q <= 1'b0;
  end

  // Payload is don't-care while mem_tvalid is low, so it carries no reset.
  always_ff @(posedge aclk) begin
    if (load) begin
      mem_queue_q <= winner;
      mem_type_q  <= request_type_t'(req_tid[winner*2 +: 2]);
      mem_req_q   <= req_tdata[winner*32 +: 32];
    end
  end

  assign mem_tvalid = mem_tvalid_q;
  assign mem_tid    = {mem_queue_q, mem_type_q};
  assign mem_tdata  = mem_req_q;

  assign cpl_fire   = cpl_tvalid && cpl_tready;
  assign dest_valid = |hit;

  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_queue
    logic [CNT_W-1:0] cnt_q;
    logic             inc, dec;

    assign hit[q]   = (cpl_tdest == QUEUE_W'(q));
    assign inc      = load && grant[q];
    assign dec      = cpl_fire && cpl_tlast && hit[q];
    assign elig[q]  = req_tvalid[q] && (cnt_q < CNT_W'(MAX_OUTSTANDING));
    assign uflow[q] = dec && !inc && (cnt_q == '0);

    always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n)                          cnt_q <= '0;
      else if (inc && !dec)                   cnt_q <= cnt_q + CNT_W'(1);
      else if (dec && !inc && cnt_q != '0)    cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Beats for a nonexistent queue are swallowed so the memory engine never stalls on them.
  always_comb begin
    cpl_tready = 1'b0;
    rsp_tvalid = '0;
    if (areset_n) begin
      cpl_tready = !dest_valid;
      for (int q = 0; q < NUM_QUEUES; q++) begin
        if (hit[q]) begin
          cpl_tready    = rsp_tready[q];
          rsp_tvalid[q] = cpl_tvalid;
        end
      end
    end
  end

  assign rsp_tlast = cpl_tlast;
  assign rsp_tdata = cpl_tdata;

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n)                                     error_q <= 1'b0;
    else if ((cpl_fire && !dest_valid) || (|uflow))    error_q <= 1'b1;
  end

  assign error = error_q;

endmodule

// File: tb/tb_virtio_available_ring_scheduler.sv
// Directed bench for the available ring scheduler: a 4-queue and a 3-queue instance.
module tb_virtio_available_ring_scheduler;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] DATA_A = {32'h00040300, 32'h00030200, 32'h00020100, 32'h00010000};
  localparam logic [31:0]  EXP_A [4] = '{32'h00010000, 32'h00020100, 32'h00030200, 32'h00040300};
  localparam logic [95:0]  DATA_B = {32'h33330002, 32'h22220001, 32'h11110000};
  localparam logic [31:0]  EXP_B [3] = '{32'h11110000, 32'h22220001, 32'h33330002};

  logic         areset_n;
  logic [3:0]   req_tvalid_a, req_tready_a;
  logic [7:0]   req_tid_a;
  logic [127:0] req_tdata_a;
  logic         mem_tvalid_a, mem_tready_a;
  logic [3:0]   mem_tid_a;
  logic [31:0]  mem_tdata_a;
  logic         cpl_tvalid_a, cpl_tready_a, cpl_tlast_a;
  logic [1:0]   cpl_tdest_a;
  logic [31:0]  cpl_tdata_a;
  logic [3:0]   rsp_tvalid_a, rsp_tready_a;
  logic         rsp_tlast_a;
  logic [31:0]  rsp_tdata_a;
  logic         error_a;

  logic         rst_b_n;
  logic [2:0]   req_tvalid_b, req_tready_b;
  logic [5:0]   req_tid_b;
  logic [95:0]  req_tdata_b;
  logic         mem_tvalid_b, mem_tready_b;
  logic [3:0]   mem_tid_b;
  logic [31:0]  mem_tdata_b;
  logic         cpl_tvalid_b, cpl_tready_b, cpl_tlast_b;
  logic [1:0]   cpl_tdest_b;
  logic [31:0]  cpl_tdata_b;
  logic [2:0]   rsp_tvalid_b, rsp_tready_b;
  logic         rsp_tlast_b;
  logic [31:0]  rsp_tdata_b;
  logic         error_b;

  virtio_available_ring_scheduler #(.NUM_QUEUES(4), .MAX_OUTSTANDING(4)) dut_a (
    .aclk(aclk), .areset_n(areset_n),
    .req_tvalid(req_tvalid_a), .req_tready(req_tready_a), .req_tid(req_tid_a), .req_tdata(req_tdata_a),
    .mem_tvalid(mem_tvalid_a), .mem_tready(mem_tready_a), .mem_tid(mem_tid_a), .mem_tdata(mem_tdata_a),
    .cpl_tvalid(cpl_tvalid_a), .cpl_tready(cpl_tready_a), .cpl_tdest(cpl_tdest_a),
    .cpl_tlast(cpl_tlast_a), .cpl_tdata(cpl_tdata_a),
    .rsp_tvalid(rsp_tvalid_a), .rsp_tready(rsp_tready_a), .rsp_tlast(rsp_tlast_a),
    .rsp_tdata(rsp_tdata_a), .error(error_a)
  );

  virtio_available_ring_scheduler #(.NUM_QUEUES(3), .MAX_OUTSTANDING(4)) dut_b (
    .aclk(aclk), .areset_n(rst_b_n),
    .req_tvalid(req_tvalid_b), .req_tready(req_tready_b), .req_tid(req_tid_b), .req_tdata(req_tdata_b),
    .mem_tvalid(mem_tvalid_b), .mem_tready(mem_tready_b), .mem_tid(mem_tid_b), .mem_tdata(mem_tdata_b),
    .cpl_tvalid(cpl_tvalid_b), .cpl_tready(cpl_tready_b), .cpl_tdest(cpl_tdest_b),
    .cpl_tlast(cpl_tlast_b), .cpl_tdata(cpl_tdata_b),
    .rsp_tvalid(rsp_tvalid_b), .rsp_tready(rsp_tready_b), .rsp_tlast(rsp_tlast_b),
    .rsp_tdata(rsp_tdata_b), .error(error_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_a();
    req_tvalid_a = '0;
    req_tid_a    = 8'hE4;
    req_tdata_a  = DATA_A;
    mem_tready_a = 1'b1;
    cpl_tvalid_a = 1'b0;
    cpl_tlast_a  = 1'b0;
    cpl_tdest_a  = '0;
    cpl_tdata_a  = '0;
    rsp_tready_a = '0;
  endtask

  task automatic reset_a();
    areset_n = 1'b0;
    idle_a();
    step();
    areset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    areset_n = 1'b0;
    rst_b_n  = 1'b0;
    idle_a();
    req_tvalid_b = '0; req_tid_b = '0; req_tdata_b = DATA_B; mem_tready_b = 1'b1;
    cpl_tvalid_b = 1'b0; cpl_tlast_b = 1'b0; cpl_tdest_b = '0; cpl_tdata_b = '0; rsp_tready_b = '0;
    step();
    step();

    // reset state with live inputs
    req_tvalid_a = 4'b1111;
    cpl_tvalid_a = 1'b1; cpl_tdest_a = 2'd1; rsp_tready_a = 4'b1111;
    #1;
    chk("rst_req_tready", req_tready_a, 4'b0000);
    chk("rst_mem_tvalid", mem_tvalid_a, 1'b0);
    chk("rst_cpl_tready", cpl_tready_a, 1'b0);
    chk("rst_rsp_tvalid", rsp_tvalid_a, 4'b0000);
    chk("rst_error", error_a, 1'b0);
    chk("rst_b_mem_tvalid", mem_tvalid_b, 1'b0);

    // round robin across all four queues
    reset_a();
    req_tvalid_a = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_req_tready", req_tready_a, 4'b0001 << (k % 4));
      step();
      chk("rr_mem_tvalid", mem_tvalid_a, 1'b1);
      chk("rr_mem_tid", mem_tid_a, (k % 4) * 5);
      chk("rr_mem_tdata", mem_tdata_a, EXP_A[k % 4]);
    end

    // single queue, payload forwarded unchanged with one cycle latency
    reset_a();
    req_tvalid_a = 4'b0100;
    req_tdata_a[95:64] = 32'h00080010;
    #1;
    chk("q2_req_tready0", req_tready_a, 4'b0100);
    step();
    chk("q2_mem_tid0", mem_tid_a, 4'hA);
    chk("q2_mem_tdata0", mem_tdata_a, 32'h00080010);
    req_tdata_a[95:64] = 32'h00080020;
    #1;
    chk("q2_req_tready1", req_tready_a, 4'b0100);
    step();
    chk("q2_mem_tdata1", mem_tdata_a, 32'h00080020);
    req_tvalid_a = 4'b0000;
    req_tdata_a  = DATA_A;
    step();
    chk("q2_drained", mem_tvalid_a, 1'b0);

    // outstanding limit on Q1, Q3 still served, completion reopens Q1
    reset_a();
    req_tvalid_a = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("lim_req_tready", req_tready_a, 4'b0010);
      step();
    end
    chk("lim_blocked", req_tready_a, 4'b0000);
    chk("lim_hold", mem_tvalid_a, 1'b1);
    step();
    chk("lim_drain", mem_tvalid_a, 1'b0);
    req_tvalid_a = 4'b1010;
    cpl_tvalid_a = 1'b1; cpl_tdest_a = 2'd1; cpl_tlast_a = 1'b1; cpl_tdata_a = 32'hCAFE0001;
    rsp_tready_a = 4'b0010;
    #1;
    chk("lim_q3_served", req_tready_a, 4'b1000);
    chk("cpl_tready_pass", cpl_tready_a, 1'b1);
    chk("rsp_tvalid_demux", rsp_tvalid_a, 4'b0010);
    chk("rsp_tdata_pass", rsp_tdata_a, 32'hCAFE0001);
    chk("rsp_tlast_pass", rsp_tlast_a, 1'b1);
    step();
    chk("lim_q3_tid", mem_tid_a, 4'hF);
    cpl_tvalid_a = 1'b0; cpl_tlast_a = 1'b0;
    req_tvalid_a = 4'b0010;
    #1;
    chk("lim_q1_reopen", req_tready_a, 4'b0010);
    step();
    chk("lim_q1_tid", mem_tid_a, 4'h5);
    cpl_tvalid_a = 1'b1; cpl_tdest_a = 2'd2; rsp_tready_a = 4'b0000;
    #1;
    chk("cpl_backpressure", cpl_tready_a, 1'b0);
    chk("rsp_tvalid_q2", rsp_tvalid_a, 4'b0100);
    cpl_tvalid_a = 1'b0;

    // memory engine stall keeps the output register stable
    reset_a();
    req_tvalid_a = 4'b0001;
    mem_tready_a = 1'b0;
    #1;
    chk("stall_first_accept", req_tready_a, 4'b0001);
    step();
    req_tvalid_a = 4'b0101;
    req_tdata_a[31:0] = 32'hDEAD0000;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_req_tready", req_tready_a, 4'b0000);
      chk("stall_mem_tvalid", mem_tvalid_a, 1'b1);
      chk("stall_mem_tid", mem_tid_a, 4'h0);
      chk("stall_mem_tdata", mem_tdata_a, 32'h00010000);
      step();
    end
    mem_tready_a = 1'b1;
    #1;
    chk("stall_release_grant", req_tready_a, 4'b0100);
    step();
    chk("stall_release_tid", mem_tid_a, 4'hA);
    chk("stall_release_tdata", mem_tdata_a, 32'h00030200);

    // completion and accept on Q1 in the same cycle leave the counter unchanged
    reset_a();
    req_tvalid_a = 4'b0010;
    step(); step(); step();
    cpl_tvalid_a = 1'b1; cpl_tdest_a = 2'd1; cpl_tlast_a = 1'b1; rsp_tready_a = 4'b0010;
    #1;
    chk("same_cycle_accept", req_tready_a, 4'b0010);
    step();
    cpl_tvalid_a = 1'b0; cpl_tlast_a = 1'b0;
    #1;
    chk("same_cycle_still_open", req_tready_a, 4'b0010);
    step();
    chk("same_cycle_now_full", req_tready_a, 4'b0000);

    // completion with no outstanding request flags an error
    reset_a();
    cpl_tvalid_a = 1'b1; cpl_tdest_a = 2'd0; cpl_tlast_a = 1'b1; rsp_tready_a = 4'b0001;
    #1;
    chk("uflow_cpl_tready", cpl_tready_a, 1'b1);
    step();
    cpl_tvalid_a = 1'b0;
    chk("uflow_error", error_a, 1'b1);
    reset_a();
    chk("uflow_error_cleared", error_a, 1'b0);

    // three queues: wrap order, bad tdest, mid-burst reset
    rst_b_n = 1'b1;
    req_tvalid_b = 3'b111;
    cpl_tvalid_b = 1'b1; cpl_tdest_b = 2'd3; cpl_tlast_b = 1'b1; rsp_tready_b = 3'b000;
    #1;
    chk("b_bad_dest_ready", cpl_tready_b, 1'b1);
    chk("b_bad_dest_rsp", rsp_tvalid_b, 3'b000);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("b_rr_req_tready", req_tready_b, 3'b001 << (k % 3));
      step();
      cpl_tvalid_b = 1'b0;
      chk("b_rr_mem_tid", mem_tid_b, (k % 3) * 4);
      chk("b_rr_mem_tdata", mem_tdata_b, EXP_B[k % 3]);
    end
    chk("b_error_sticky", error_b, 1'b1);
    #2;
    rst_b_n = 1'b0;
    cpl_tvalid_b = 1'b1; cpl_tdest_b = 2'd0; rsp_tready_b = 3'b001;
    #1;
    chk("b_midrst_mem_tvalid", mem_tvalid_b, 1'b0);
    chk("b_midrst_req_tready", req_tready_b, 3'b000);
    chk("b_midrst_error", error_b, 1'b0);
    chk("b_midrst_cpl_tready", cpl_tready_b, 1'b0);
    chk("b_midrst_rsp_tvalid", rsp_tvalid_b, 3'b000);
    step();
    rst_b_n = 1'b1;
    cpl_tvalid_b = 1'b0;
    #1;
    chk("b_after_rst_ptr", req_tready_b, 3'b001);
    step();
    chk("b_after_rst_tid", mem_tid_b, 4'h0);
    chk("b_after_rst_tdata", mem_tdata_b, 32'h11110000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
